// File: rtl/rv_decode_stage.sv
// RV32I/F instruction decode stage: format classification, register/tag extraction and
// immediate assembly, buffered in a 2-entry FIFO. Define RV_FP_DECODE_EN to decode F-extension opcodes.
module rv_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [6:0]       out_op,
    output logic [2:0]       out_fmt,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [1:0]       out_funct2,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rs3,
    output logic [4:0]       out_rd,
    output logic             out_rs1_fp,
    output logic             out_rs2_fp,
    output logic             out_rs3_fp,
    output logic             out_rd_fp,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_R4  = 3'd6,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      op;
        fmt_e            fmt;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [1:0]      funct2;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rs3;
        logic [4:0]      rd;
        logic            rs1_fp;
        logic            rs2_fp;
        logic            rs3_fp;
        logic            rd_fp;
        logic [XLEN-1:0] imm;
    } dec_t;

    fmt_e               w_fmt;
    logic               w_rs1_fp;
    logic               w_rs2_fp;
    logic               w_rs3_fp;
    logic               w_rd_fp;
    logic signed [31:0] w_imm32;
    dec_t               w_dec;
    dec_t               w_head;
    logic               w_push;
    logic               w_pop;

    logic [1:0]         r_count;
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [CNT_W-1:0]   r_illegal_cnt;
    dec_t               r_mem [2];

    // Every listed opcode ends in 2'b11, so a bad i[1:0] always lands in the illegal default.
    // NOTE: every combinational output gets a default before the case so no path can infer a latch.
    always_comb begin
        w_fmt    = FMT_ILL;
        w_rs1_fp = 1'b0;
        w_rs2_fp = 1'b0;
        w_rs3_fp = 1'b0;
        w_rd_fp  = 1'b0;
        case (in_instr[6:0])
            7'b0110011:                         w_fmt = FMT_R;
            7'b0000011, 7'b0010011, 7'b1100111: w_fmt = FMT_I;
            7'b0100011:                         w_fmt = FMT_S;
            7'b1100011:                         w_fmt = FMT_B;
            7'b0110111, 7'b0010111:             w_fmt = FMT_U;
            7'b1101111:                         w_fmt = FMT_J;
`ifdef RV_FP_DECODE_EN
            7'b0000111: begin
                w_fmt   = FMT_I;
                w_rd_fp = 1'b1;
            end
            7'b0100111: begin
                w_fmt    = FMT_S;
                w_rs2_fp = 1'b1;
            end
            7'b1010011: begin
                w_fmt    = FMT_R;
                w_rs1_fp = !(in_instr[31:25] inside {7'b1101000, 7'b1111000});
                w_rs2_fp = 1'b1;
                w_rd_fp  = !(in_instr[31:25] inside {7'b1010000, 7'b1100000, 7'b1110000});
            end
            7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
                w_fmt    = FMT_R4;
                w_rs1_fp = 1'b1;
                w_rs2_fp = 1'b1;
                w_rs3_fp = 1'b1;
                w_rd_fp  = 1'b1;
            end
`else
            // FP opcodes fall into the illegal default and every *_fp tag stays 0.
`endif
            default:                            w_fmt = FMT_ILL;
        endcase
    end

    always_comb begin
        w_dec        = '0;
        w_imm32      = '0;
        w_dec.pc     = in_pc;
        w_dec.op     = in_instr[6:0];
        w_dec.fmt    = w_fmt;
        w_dec.rs1_fp = w_rs1_fp;
        w_dec.rs2_fp = w_rs2_fp;
        w_dec.rs3_fp = w_rs3_fp;
        w_dec.rd_fp  = w_rd_fp;
        case (w_fmt)
            FMT_R: begin
                w_dec.funct3 = in_instr[14:12];
                w_dec.funct7 = in_instr[31:25];
                w_dec.rs1    = in_instr[19:15];
                w_dec.rs2    = in_instr[24:20];
                w_dec.rd     = in_instr[11:7];
            end
            FMT_I: begin
                w_dec.funct3 = in_instr[14:12];
                w_dec.rs1    = in_instr[19:15];
                w_dec.rd     = in_instr[11:7];
                w_imm32      = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            FMT_S: begin
                w_dec.funct3 = in_instr[14:12];
                w_dec.rs1    = in_instr[19:15];
                w_dec.rs2    = in_instr[24:20];
                w_imm32      = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            FMT_B: begin
                w_dec.funct3 = in_instr[14:12];
                w_dec.rs1    = in_instr[19:15];
                w_dec.rs2    = in_instr[24:20];
                w_imm32      = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                                in_instr[11:8], 1'b0};
            end
            FMT_U: begin
                w_dec.rd = in_instr[11:7];
                w_imm32  = {in_instr[31:12], 12'b0};
            end
            FMT_J: begin
                w_dec.rd = in_instr[11:7];
                w_imm32  = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                            in_instr[30:21], 1'b0};
            end
            FMT_R4: begin
                w_dec.funct3 = in_instr[14:12];
                w_dec.funct2 = in_instr[26:25];
                w_dec.rs1    = in_instr[19:15];
                w_dec.rs2    = in_instr[24:20];
                w_dec.rs3    = in_instr[31:27];
                w_dec.rd     = in_instr[11:7];
            end
            default: ;
        endcase
        // Signed 32-bit source, so the width cast sign-extends for XLEN=64.
        w_dec.imm = XLEN'(w_imm32);
    end

    assign in_ready  = (r_count != 2'd2) & rst_n;
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count       <= 2'd0;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_illegal_cnt <= '0;
        end else if (flush) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_pop && (w_head.fmt == FMT_ILL) && (r_illegal_cnt != '1))
                r_illegal_cnt <= r_illegal_cnt + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; outputs are masked to 0 while empty instead.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_dec;
    end

    assign w_head = out_valid ? r_mem[r_rd_ptr] : '0;

    assign out_pc      = w_head.pc;
    assign out_op      = w_head.op;
    assign out_fmt     = w_head.fmt;
    assign out_funct3  = w_head.funct3;
    assign out_funct7  = w_head.funct7;
    assign out_funct2  = w_head.funct2;
    assign out_rs1     = w_head.rs1;
    assign out_rs2     = w_head.rs2;
    assign out_rs3     = w_head.rs3;
    assign out_rd      = w_head.rd;
    assign out_rs1_fp  = w_head.rs1_fp;
    assign out_rs2_fp  = w_head.rs2_fp;
    assign out_rs3_fp  = w_head.rs3_fp;
    assign out_rd_fp   = w_head.rd_fp;
    assign out_imm     = w_head.imm;
    assign out_illegal = out_valid & (w_head.fmt == FMT_ILL);
    assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage: accepted instructions are decoded by a reference model
// into an expected queue; a negedge monitor compares every presented entry and the illegal counter.
module tb_rv_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [2:0]  fmt;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [1:0]  f2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rs3;
        logic [4:0]  rd;
        logic [3:0]  fp;   // {rs1, rs2, rs3, rd}
        logic [31:0] imm;
        logic        ill;
    } rec_t;

`ifdef RV_FP_DECODE_EN
    localparam bit FP_EN = 1'b1;
`else
    localparam bit FP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  out_op;
    logic [2:0]  out_fmt;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [1:0]  out_funct2;
    logic [4:0]  out_rs1, out_rs2, out_rs3, out_rd;
    logic        out_rs1_fp, out_rs2_fp, out_rs3_fp, out_rd_fp;
    logic [31:0] out_imm;
    logic        out_illegal;
    logic [1:0]  illegal_cnt;

    logic        dir_ready = 1'b0;
    logic        rnd_ready = 1'b1;
    logic        rand_mode = 1'b0;
    assign out_ready = rand_mode ? rnd_ready : dir_ready;

    rec_t        exp_q[$];
    logic [1:0]  exp_cnt = '0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    rv_decode_stage #(.XLEN(32), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
        .out_fmt(out_fmt), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_funct2(out_funct2), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs3(out_rs3),
        .out_rd(out_rd), .out_rs1_fp(out_rs1_fp), .out_rs2_fp(out_rs2_fp),
        .out_rs3_fp(out_rs3_fp), .out_rd_fp(out_rd_fp), .out_imm(out_imm),
        .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference decode: format from opcode class, fields from what each format uses,
    // immediate from weighted bit groups with a negative weight on the sign bit.
    function automatic rec_t model(input logic [31:0] ins, input logic [31:0] pc);
        rec_t r;
        int   imm;
        logic [6:0] op;
        op    = ins[6:0];
        r     = '0;
        r.pc  = pc;
        r.op  = op;
        r.fmt = 3'd7;
        imm   = 0;
        if (ins[1:0] == 2'b11) begin
            if (op == 7'h33) r.fmt = 3'd0;
            else if (op inside {7'h03, 7'h13, 7'h67}) r.fmt = 3'd1;
            else if (op == 7'h23) r.fmt = 3'd2;
            else if (op == 7'h63) r.fmt = 3'd3;
            else if (op inside {7'h37, 7'h17}) r.fmt = 3'd4;
            else if (op == 7'h6F) r.fmt = 3'd5;
            else if (FP_EN && op == 7'h07) begin r.fmt = 3'd1; r.fp = 4'b0001; end
            else if (FP_EN && op == 7'h27) begin r.fmt = 3'd2; r.fp = 4'b0100; end
            else if (FP_EN && op == 7'h53) begin
                r.fmt   = 3'd0;
                r.fp[3] = !(ins[31:25] == 7'h68 || ins[31:25] == 7'h78);
                r.fp[2] = 1'b1;
                r.fp[0] = !(ins[31:25] == 7'h50 || ins[31:25] == 7'h60 || ins[31:25] == 7'h70);
            end
            else if (FP_EN && op inside {7'h43, 7'h47, 7'h4B, 7'h4F}) begin
                r.fmt = 3'd6;
                r.fp  = 4'b1111;
            end
        end
        if (r.fmt inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6}) r.rd  = ins[11:7];
        if (r.fmt inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd6}) begin
            r.rs1 = ins[19:15];
            r.f3  = ins[14:12];
        end
        if (r.fmt inside {3'd0, 3'd2, 3'd3, 3'd6}) r.rs2 = ins[24:20];
        if (r.fmt == 3'd0) r.f7 = ins[31:25];
        if (r.fmt == 3'd6) begin
            r.rs3 = ins[31:27];
            r.f2  = ins[26:25];
        end
        case (r.fmt)
            3'd1: imm = int'(ins[31:20]) - (ins[31] ? 4096 : 0);
            3'd2: imm = int'({ins[31:25], ins[11:7]}) - (ins[31] ? 4096 : 0);
            3'd3: imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                        + int'(ins[11:8]) * 2;
            3'd4: imm = int'(ins & 32'hFFFF_F000);
            3'd5: imm = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096
                        + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            default: imm = 0;
        endcase
        r.imm = imm;
        r.ill = (r.fmt == 3'd7);
        return r;
    endfunction

    function automatic rec_t dut_rec();
        rec_t r;
        r = {out_pc, out_op, out_fmt, out_funct3, out_funct7, out_funct2,
             out_rs1, out_rs2, out_rs3, out_rd,
             out_rs1_fp, out_rs2_fp, out_rs3_fp, out_rd_fp, out_imm, out_illegal};
        return r;
    endfunction

    // Monitor: compares the queue head whenever an entry is presented, retires it on a real pop.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt = '0;
        end else begin
            check("illegal_cnt", illegal_cnt, exp_cnt);
            if (out_valid) begin
                if (exp_q.size() == 0) check("out_valid_unexpected", out_valid, 1'b0);
                else begin
                    check("entry", dut_rec(), exp_q[0]);
                    if (out_ready && !flush) begin
                        if (exp_q[0].ill && exp_cnt != 2'b11) exp_cnt = exp_cnt + 2'd1;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (flush) exp_q.delete();
        end
    end

    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            rnd_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
        end
    end

    task automatic send(input logic [31:0] ins);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc_ctr;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (in_ready && rst_n && !flush) begin
                exp_q.push_back(model(ins, pc_ctr));
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        pc_ctr   = pc_ctr + 32'd4;
        check("send_accepted", done, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_illegal_cnt", illegal_cnt, 2'd0);
        check("rst_fields", dut_rec(), '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1'b1);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [16] = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
                                  7'h6F, 7'h07, 7'h27, 7'h53, 7'h43, 7'h47, 7'h4B, 7'h4F};
        logic [6:0]  f7s [5] = '{7'h50, 7'h60, 7'h70, 7'h68, 7'h78};
        logic [31:0] ins;
        ins = $urandom;
        if ($urandom_range(0, 9) != 0) ins[6:0] = ops[$urandom_range(0, 15)];
        if (ins[6:0] == 7'h53 && $urandom_range(0, 1) == 1) ins[31:25] = f7s[$urandom_range(0, 4)];
        return ins;
    endfunction

    logic [1:0] sat_tbl [4] = '{2'd1, 2'd2, 2'd3, 2'd3};

    initial begin
        @(posedge clk); #1;
        do_reset();

        // Directed decodes, one at a time with the consumer ready.
        dir_ready = 1'b1;
        send(32'hFFF0_8293);
        @(negedge clk);
        check("addi_valid", out_valid, 1'b1);
        check("addi_fmt", out_fmt, 3'd1);
        check("addi_rs1", out_rs1, 5'd1);
        check("addi_rd", out_rd, 5'd5);
        check("addi_imm", out_imm, 32'hFFFF_FFFF);
        check("addi_illegal", out_illegal, 1'b0);
        @(posedge clk); #1;
        send(32'hFE20_8EE3);
        @(negedge clk);
        check("beq_fmt", out_fmt, 3'd3);
        check("beq_rs2", out_rs2, 5'd2);
        check("beq_imm", out_imm, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        send(32'h0010_00EF);
        @(negedge clk);
        check("jal_fmt", out_fmt, 3'd5);
        check("jal_imm", out_imm, 32'h0000_0800);
        @(posedge clk); #1;
        send(32'h2031_00C3);
        @(negedge clk);
        check("fmadd_fmt", out_fmt, FP_EN ? 3'd6 : 3'd7);
        check("fmadd_rs3", out_rs3, FP_EN ? 5'd4 : 5'd0);
        @(posedge clk); #1;

        // Illegal counter saturation from a clean count.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send(32'h0000_0000);
            @(negedge clk);
            check("zero_illegal", out_illegal, 1'b1);
            @(negedge clk);
            check("illegal_cnt_sat", illegal_cnt, sat_tbl[k]);
            @(posedge clk); #1;
        end

        // Back-pressure: two accepted, third stalls until the first pop.
        dir_ready = 1'b0;
        send(32'h0020_8133);
        send(32'h0041_2183);
        in_valid = 1'b1;
        in_instr = 32'h1234_52B7;
        in_pc    = pc_ctr;
        @(negedge clk);
        check("full_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        dir_ready = 1'b1;
        @(negedge clk);
        check("full_in_ready_pre_pop", in_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("in_ready_after_pop", in_ready, 1'b1);
        if (in_ready) exp_q.push_back(model(in_instr, pc_ctr));
        @(posedge clk); #1;
        in_valid = 1'b0;
        pc_ctr   = pc_ctr + 32'd4;
        repeat (3) @(posedge clk);
        #1;

        // Flush with a full buffer and a concurrent offer, then with one entry.
        dir_ready = 1'b0;
        send(32'h0000_0013);
        send(32'h0000_1063);
        for (int n = 0; n < 2; n++) begin
            in_valid = 1'b1;
            in_instr = 32'h00A0_0093;
            flush    = 1'b1;
            @(posedge clk); #1;
            flush    = 1'b0;
            in_valid = 1'b0;
            @(negedge clk);
            check("flush_out_valid", out_valid, 1'b0);
            dir_ready = 1'b1;
            repeat (3) @(negedge clk);
            check("flush_nothing_delivered", out_valid, 1'b0);
            @(posedge clk); #1;
            dir_ready = 1'b0;
            send(32'h0050_0113);
        end
        dir_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Randomized traffic with random back-pressure and occasional flush.
        rand_mode = 1'b1;
        for (int k = 0; k < 400; k++) begin
            send(rand_instr());
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rand_mode = 1'b0;
        @(posedge clk); #2;
        flush     = 1'b0;
        dir_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        check("drain_empty", exp_q.size(), 0);

        // Reset in the middle of a full buffer.
        dir_ready = 1'b0;
        @(posedge clk); #1;
        send(32'h0000_0000);
        send(32'hFFF0_8293);
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
